mux_scan_n: RTL and testbench

//   Parametrised N-channel, WIDTH-bit registered multiplexer with active-high enable.

---
 rtl/mux_scan_n_if.sv | 28 ++
 rtl/mux_scan_n.sv | 114 +++++++++++
 tb/tb_mux_scan_n.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mux_scan_n_if.sv
// Bus bundle for mux_scan_n: control/select/data inputs and registered outputs.
interface mux_scan_n_if #(
   parameter int N       = 10,
   parameter int WIDTH   = 1,
   parameter int SEL_W   = 4,
   parameter int DWELL_W = 8
);
   logic                 en;
   logic                 mode;
   logic [SEL_W-1:0]     sel_in;
   logic [DWELL_W-1:0]   dwell;
   logic [N*WIDTH-1:0]   din;
   logic [WIDTH-1:0]     y;
   logic                 y_valid;
   logic [SEL_W-1:0]     cur_sel;
   logic                 wrap;
   logic                 sel_err;

   modport master (
      output en, mode, sel_in, dwell, din,
      input  y, y_valid, cur_sel, wrap, sel_err
   );

   modport slave (
      input  en, mode, sel_in, dwell, din,
      output y, y_valid, cur_sel, wrap, sel_err
   );
endinterface

// File: rtl/mux_scan_n.sv
// N-channel registered multiplexer with manual select and a dwell-timed scan sequencer.
module mux_scan_n #(
   parameter int N       = 10,
   parameter int WIDTH   = 1,
   parameter int SEL_W   = 4,
   parameter int DWELL_W = 8
) (
   input  logic           clk,
   input  logic           rst,
   mux_scan_n_if.slave    bus
);
   localparam logic [0:0]       ST_MANUAL = 1'b0;
   localparam logic [0:0]       ST_SCAN   = 1'b1;
   localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(N - 1);
   localparam logic [SEL_W:0]   N_EXT     = (SEL_W + 1)'(N);

   logic [0:0]         state_q,   state_d;
   logic [SEL_W-1:0]   ptr_q,     ptr_d;
   logic [DWELL_W-1:0] cnt_q,     cnt_d;
   logic [WIDTH-1:0]   y_q,       y_d;
   logic               y_valid_q, y_valid_d;
   logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
   logic               wrap_q,    wrap_d;
   logic               sel_err_q, sel_err_d;

   logic [SEL_W-1:0]   scan_ptr;
   logic [DWELL_W-1:0] scan_cnt;
   logic               sel_ok;

   // Extract one channel slice; callers guarantee s < N.
   function automatic logic [WIDTH-1:0] pick(input logic [N*WIDTH-1:0] d,
                                             input logic [SEL_W-1:0]   s);
      int idx;
      idx  = int'(s);
      pick = d[idx*WIDTH +: WIDTH];
   endfunction

   assign sel_ok = ({1'b0, bus.sel_in} < N_EXT);

   // Next-state: disabled cycles blank the outputs but freeze the sequencer;
   // entering scan from manual starts channel 0 with a fresh dwell count.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      cur_sel_d = cur_sel_q;
      y_d       = '0;
      y_valid_d = 1'b0;
      wrap_d    = 1'b0;
      sel_err_d = 1'b0;
      scan_ptr  = (state_q == ST_SCAN) ? ptr_q : '0;
      scan_cnt  = (state_q == ST_SCAN) ? cnt_q : '0;
      if (bus.en) begin
         if (bus.mode) begin
            state_d   = ST_SCAN;
            y_d       = pick(bus.din, scan_ptr);
            y_valid_d = 1'b1;
            cur_sel_d = scan_ptr;
            if (scan_cnt >= bus.dwell) begin
               cnt_d = '0;
               if (scan_ptr == LAST_CH) begin
                  ptr_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  ptr_d = scan_ptr + SEL_W'(1);
               end
            end else begin
               ptr_d = scan_ptr;
               cnt_d = scan_cnt + DWELL_W'(1);
            end
         end else begin
            state_d   = ST_MANUAL;
            ptr_d     = '0;
            cnt_d     = '0;
            cur_sel_d = bus.sel_in;
            if (sel_ok) begin
               y_d       = pick(bus.din, bus.sel_in);
               y_valid_d = 1'b1;
            end else begin
               sel_err_d = 1'b1;
            end
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_MANUAL;
         ptr_q     <= '0;
         cnt_q     <= '0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
         cur_sel_q <= '0;
         wrap_q    <= 1'b0;
         sel_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
         cur_sel_q <= cur_sel_d;
         wrap_q    <= wrap_d;
         sel_err_q <= sel_err_d;
      end
   end

   assign bus.y       = y_q;
   assign bus.y_valid = y_valid_q;
   assign bus.cur_sel = cur_sel_q;
   assign bus.wrap    = wrap_q;
   assign bus.sel_err = sel_err_q;
endmodule

// File: tb/tb_mux_scan_n.sv
// Scoreboard bench for mux_scan_n with N=10, WIDTH=8, channel k carrying 8'h10+k.
module tb_mux_scan_n;
   localparam int N = 10, WIDTH = 8, SEL_W = 4, DWELL_W = 8;

   typedef struct packed {
      logic [7:0] y;
      logic       v;
      logic [3:0] cs;
      logic       w;
      logic       se;
   } obs_t;

   logic clk = 1'b0;
   logic rst;
   obs_t exp_q[$];
   obs_t obs, e;
   int   vectors = 0;
   int   miscompares = 0;

   mux_scan_n_if #(.N(N), .WIDTH(WIDTH), .SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

   mux_scan_n #(.N(N), .WIDTH(WIDTH), .SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign obs = {bus.y, bus.y_valid, bus.cur_sel, bus.wrap, bus.sel_err};

   function automatic obs_t mk(input int y, input bit v, input int cs, input bit w, input bit se);
      obs_t o;
      o.y  = 8'(y);
      o.v  = v;
      o.cs = 4'(cs);
      o.w  = w;
      o.se = se;
      return o;
   endfunction

   function automatic obs_t chan(input int ch, input bit w);
      return mk(8'h10 + ch, 1'b1, ch, w, 1'b0);
   endfunction

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         rst = 1'b1; bus.en = 1'b1; bus.mode = 1'b1;
         exp_q.push_back(mk(0, 0, 0, 0, 0));
         @(posedge clk); #1;
         e = exp_q.pop_front(); vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL reset[%0d]: got %h want %h", i, obs, e);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_manual();
      int sels[6] = '{7, 0, 9, 12, 3, 10};
      for (int i = 0; i < 6; i++) begin
         bus.en = 1'b1; bus.mode = 1'b0; bus.sel_in = 4'(sels[i]);
         if (sels[i] < N) exp_q.push_back(chan(sels[i], 1'b0));
         else             exp_q.push_back(mk(0, 0, sels[i], 0, 1));
         @(posedge clk); #1;
         e = exp_q.pop_front(); vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL manual sel=%0d: got %h want %h", sels[i], obs, e);
         end
      end
   endtask

   // One manual cycle on channel 0, then dwell=2 scan for a full sweep plus one.
   task automatic test_scan();
      for (int i = 0; i < 32; i++) begin
         bus.en = 1'b1; bus.dwell = 8'd2; bus.sel_in = 4'd0;
         bus.mode = (i != 0);
         if (i == 0) exp_q.push_back(chan(0, 1'b0));
         else        exp_q.push_back(chan(((i - 1) / 3) % N, (i - 1) == 29));
         @(posedge clk); #1;
         e = exp_q.pop_front(); vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL scan[%0d]: got %h want %h", i, obs, e);
         end
      end
   endtask

   // en dropped for 4 cycles after ch 4 has been shown once.
   task automatic test_enable();
      int j = 0;
      for (int i = 0; i < 24; i++) begin
         bus.dwell = 8'd2; bus.sel_in = 4'd0;
         bus.mode = (i != 0);
         bus.en   = !(i >= 14 && i <= 17);
         if (i == 0)       exp_q.push_back(chan(0, 1'b0));
         else if (!bus.en) exp_q.push_back(mk(0, 0, 4, 0, 0));
         else begin
            exp_q.push_back(chan(j / 3, 1'b0));
            j++;
         end
         @(posedge clk); #1;
         e = exp_q.pop_front(); vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL enable[%0d]: got %h want %h", i, obs, e);
         end
      end
   endtask

   // Reset pulse while scanning ch 5; scan must restart at ch 0 with a full dwell.
   task automatic test_reset_mid();
      int j = 0;
      for (int i = 0; i < 22; i++) begin
         bus.en = 1'b1; bus.dwell = 8'd2; bus.sel_in = 4'd0;
         bus.mode = (i != 0);
         rst = (i == 17);
         if (i == 0)       exp_q.push_back(chan(0, 1'b0));
         else if (i == 17) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0));
            j = 0;
         end else begin
            exp_q.push_back(chan(j / 3, 1'b0));
            j++;
         end
         @(posedge clk); #1;
         e = exp_q.pop_front(); vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL reset_mid[%0d]: got %h want %h", i, obs, e);
         end
      end
      rst = 1'b0;
   endtask

   // dwell=0 steps one channel per cycle, wrap on the ch 9 sample.
   task automatic test_dwell0();
      for (int i = 0; i < 13; i++) begin
         bus.en = 1'b1; bus.dwell = 8'd0; bus.sel_in = 4'd0;
         bus.mode = (i != 0);
         if (i == 0) exp_q.push_back(chan(0, 1'b0));
         else        exp_q.push_back(chan((i - 1) % N, (i - 1) == 9));
         @(posedge clk); #1;
         e = exp_q.pop_front(); vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL dwell0[%0d]: got %h want %h", i, obs, e);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; bus.en = 1'b0; bus.mode = 1'b0; bus.sel_in = '0; bus.dwell = '0;
      for (int k = 0; k < N; k++) bus.din[k*WIDTH +: WIDTH] = 8'(8'h10 + k);
      @(posedge clk); #1;
      test_reset();
      test_manual();
      test_scan();
      test_enable();
      test_reset_mid();
      test_dwell0();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
